fp_normalizer: RTL and testbench
================================

// Module: fp_normalizer
// PURPOSE
//  Post-add/sub normalize-and-round stage of the FP add/sub unit. Takes the raw signed sum
//  (carry bit, mantissa with hidden bit, guard/round/sticky bits) and the pre-normalization biased exponent.
//  Normalizes left or right, rounds to nearest-even, handles subnormal/overflow and registers a packed IEEE-style word.
// PARAMETERS
//  EXPONENT_WIDTH  5   biased exponent width (bias = 2^(EXPONENT_WIDTH-1)-1)
//  MANTISSA_WIDTH  11  mantissa width INCLUDING hidden bit; stored fraction = MANTISSA_WIDTH-1 bits
// PORTS
//  clk_i              in   1     clock, all state on rising edge
//  rst_ni             in   1     reset, synchronous, active-low
//  sign_i             in   1     sign of sum
//  exp_i              in   E     biased exponent before normalization
//  mant_carry_bit_i   in   1     carry-out of mantissa add (weight 2^1 vs hidden bit)
//  mant_i             in   M     sum mantissa, bit M-1 = hidden-bit position
//  mant_guard_bit_i   in   1     guard bit (first below LSB)
//  mant_round_bit_i   in   1     round bit
//  mant_sticky_bit_i  in   1     sticky bit (OR of all lower bits)
//  result_o           out  E+M   {sign, exp[E-1:0], frac[M-2:0]}; 16 bits for the defaults
// BEHAVIOUR
//  - One clock, synchronous active-low reset (rst_ni); rst_ni=0 at an edge -> result_o=0. Result registered; latency 1 cycle:
//    inputs sampled at rising edge N appear on result_o after edge N, held until next edge. No handshake; new op every cycle.
//  - Working vector V = {mant_i, G, R, S} (M+3 bits).
//  - Carry path (mant_carry_bit_i=1): shift right 1: mant'={1,mant_i[M-1:1]}, G'=mant_i[0], R'=G, S'=R|S; exp'=exp_i+1.
//  - No carry: lz = leading zeros of mant_i. Shift = min(lz, max(exp_i-1,0)).
//    V'=V<<shift, zero fill (S' is the bit landing in sticky position); exp'=exp_i-shift.
//    If shift<lz (underflow limit hit) or mant' bit M-1 = 0, result is subnormal: exp field = 0.
//  - Rounding RNE: round_up = G' & (R'|S'|mant'[0]). mant'' = mant'+round_up.
//    Rounding overflow (mant'' = 2^M) -> mant''>>1, exp'+1.
//    Subnormal rounding into bit M-1 -> exp field becomes 1 (normal).
//  - Overflow: exp' >= 2^E-1 after all steps -> {sign_i, all-ones exp, zero frac} (infinity).
//  - Zero: mant_i=0, carry=0, G=R=S=0 -> {sign_i, 0, 0} (signed zero kept).
//  - Output frac = mant''[M-2:0] (hidden bit dropped). Purely combinational datapath ahead of one output register.
// TESTING (E=5, M=11; each vector held one cycle, check result after next edge)
//  - s=1 e=28 c=0 m=001_1110_1010 GRS=111 -> lz=2, tie round-up: 0xEBAC
//  - s=1 e=20 c=1 m=001_1010_1010 GRS=101 -> right shift, exp 21, no round: 0xD4D5
//  - s=0 e=10 c=0 m=000_0000_0001 GRS=101 -> subnormal, shift 9: 0x0340
//  - s=1 e=16 c=0 m=011_1111_1111 GRS=110 -> shift 1, round overflow renormalizes: 0xC000
//  - s=0 e=30 c=1 m=100_0000_0000 GRS=000 -> exponent overflow: 0x7C00; then all-zero input with s=1 -> 0x8000
//  - rst_ni=0 for one edge mid-stream -> result_o=0x0000 after that edge; next op resumes with 1-cycle latency

Source files
------------

// File: rtl/fp_normalizer.sv
// rtl/fp_normalizer.sv - normalize, round-to-nearest-even and pack stage of the FP add/sub unit
module fp_normalizer #(
    parameter int EXPONENT_WIDTH = 5,
    parameter int MANTISSA_WIDTH = 11
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    sign_i,
    input  logic [EXPONENT_WIDTH-1:0]               exp_i,
    input  logic                                    mant_carry_bit_i,
    input  logic [MANTISSA_WIDTH-1:0]               mant_i,
    input  logic                                    mant_guard_bit_i,
    input  logic                                    mant_round_bit_i,
    input  logic                                    mant_sticky_bit_i,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] result_o
);

    localparam int E   = EXPONENT_WIDTH;
    localparam int M   = MANTISSA_WIDTH;
    localparam int W   = E + M;
    localparam int VW  = M + 3;
    localparam int LZW = $clog2(M + 1);
    // Shared width for exponent/shift arithmetic with headroom for two increments.
    localparam int SW  = ((LZW > E) ? LZW : E) + 2;

    localparam logic [SW-1:0] EXP_MAX = SW'((1 << E) - 1);
    localparam logic [SW-1:0] ONE     = SW'(1);

    function automatic logic [LZW-1:0] count_lz(input logic [M-1:0] m);
        logic [LZW-1:0] lz;
        lz = LZW'(M);
        for (int i = 0; i < M; i++) begin
            if (m[i]) begin
                lz = LZW'(M - 1 - i);
            end
        end
        return lz;
    endfunction

    logic [SW-1:0]  lz;
    logic [SW-1:0]  exp_ext;
    logic [SW-1:0]  shift_limit;
    logic [SW-1:0]  shift;
    logic [VW-1:0]  v_shift;
    logic [M-1:0]   mant_n;
    logic           guard_n;
    logic           round_n;
    logic           sticky_n;
    logic [SW-1:0]  exp_n;
    logic           subnormal;
    logic           round_up;
    logic [M:0]     mant_r;
    logic [M-1:0]   mant_f;
    logic [SW-1:0]  exp_f;
    logic [E-1:0]   exp_field;
    logic           is_zero;
    logic           is_inf;
    logic [W-1:0]   result_d;

    always_comb begin
        lz          = SW'(count_lz(mant_i));
        exp_ext     = SW'(exp_i);
        shift_limit = (exp_ext == '0) ? '0 : exp_ext - ONE;
        shift       = (lz < shift_limit) ? lz : shift_limit;
        v_shift     = '0;
        mant_n      = '0;
        guard_n     = 1'b0;
        round_n     = 1'b0;
        sticky_n    = 1'b0;
        exp_n       = '0;
        subnormal   = 1'b0;

        if (mant_carry_bit_i) begin
            mant_n   = {1'b1, mant_i[M-1:1]};
            guard_n  = mant_i[0];
            round_n  = mant_guard_bit_i;
            sticky_n = mant_round_bit_i | mant_sticky_bit_i;
            exp_n    = exp_ext + ONE;
        end else begin
            v_shift  = {mant_i, mant_guard_bit_i, mant_round_bit_i, mant_sticky_bit_i} << shift;
            mant_n   = v_shift[VW-1:3];
            guard_n  = v_shift[2];
            round_n  = v_shift[1];
            sticky_n = v_shift[0];
            exp_n    = exp_ext - shift;
            // Exponent floor reached before the hidden bit was restored.
            subnormal = (shift < lz) || !v_shift[VW-1];
        end

        round_up = guard_n & (round_n | sticky_n | mant_n[0]);
        mant_r   = {1'b0, mant_n} + {{M{1'b0}}, round_up};

        if (mant_r[M]) begin
            mant_f = mant_r[M:1];
            exp_f  = exp_n + ONE;
        end else begin
            mant_f = mant_r[M-1:0];
            exp_f  = exp_n;
        end

        // A subnormal that rounds up into the hidden-bit position becomes the smallest normal.
        if (subnormal) begin
            exp_field = mant_f[M-1] ? E'(1) : '0;
        end else begin
            exp_field = exp_f[E-1:0];
        end

        is_zero = !mant_carry_bit_i && (mant_i == '0) &&
                  !mant_guard_bit_i && !mant_round_bit_i && !mant_sticky_bit_i;
        is_inf  = !subnormal && (exp_f >= EXP_MAX);

        if (is_zero) begin
            result_d = {sign_i, {(W-1){1'b0}}};
        end else if (is_inf) begin
            result_d = {sign_i, {E{1'b1}}, {(M-1){1'b0}}};
        end else begin
            result_d = {sign_i, exp_field, mant_f[M-2:0]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            result_o <= '0;
        end else begin
            result_o <= result_d;
        end
    end

endmodule

// File: tb/tb_fp_normalizer.sv
// tb/tb_fp_normalizer.sv - directed scoreboard bench for fp_normalizer (E=5, M=11)
module tb_fp_normalizer;

    logic        clk;
    logic        rst_n;
    logic        sign;
    logic [4:0]  exp_in;
    logic        carry;
    logic [10:0] mant;
    logic        guard_bit;
    logic        round_bit;
    logic        sticky_bit;
    logic [15:0] result;

    logic [15:0] exp_q[$];
    string       tag_q[$];
    int          passed;
    int          total;

    fp_normalizer #(
        .EXPONENT_WIDTH(5),
        .MANTISSA_WIDTH(11)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .sign_i           (sign),
        .exp_i            (exp_in),
        .mant_carry_bit_i (carry),
        .mant_i           (mant),
        .mant_guard_bit_i (guard_bit),
        .mant_round_bit_i (round_bit),
        .mant_sticky_bit_i(sticky_bit),
        .result_o         (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_out();
        logic [15:0] want;
        string       tag;
        total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h expected <entry>", result);
        end else begin
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            assert (result === want) passed++;
            else $error("FAIL %s: observed %h expected %h", tag, result, want);
        end
    endtask

    task automatic step(input logic s, input logic [4:0] e, input logic c,
                        input logic [10:0] m, input logic [2:0] grs,
                        input logic [15:0] want, input string tag);
        sign       = s;
        exp_in     = e;
        carry      = c;
        mant       = m;
        guard_bit  = grs[2];
        round_bit  = grs[1];
        sticky_bit = grs[0];
        exp_q.push_back(want);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        sign = 1'b1; exp_in = 5'd28; carry = 1'b0; mant = 11'b001_1110_1010;
        guard_bit = 1'b1; round_bit = 1'b1; sticky_bit = 1'b1;
        exp_q.push_back(16'h0000);
        tag_q.push_back("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_out();
        rst_n = 1'b1;

        step(1'b1, 5'd28, 1'b0, 11'b001_1110_1010, 3'b111, 16'hEBAC, "lz2_tie_up");
        step(1'b1, 5'd20, 1'b1, 11'b001_1010_1010, 3'b101, 16'hD4D5, "carry_shift_right");
        step(1'b0, 5'd10, 1'b0, 11'b000_0000_0001, 3'b101, 16'h0340, "subnormal_shift9");
        step(1'b1, 5'd16, 1'b0, 11'b011_1111_1111, 3'b110, 16'hC000, "round_renorm");
        step(1'b0, 5'd30, 1'b1, 11'b100_0000_0000, 3'b000, 16'h7C00, "exp_overflow");
        step(1'b1, 5'd0,  1'b0, 11'b000_0000_0000, 3'b000, 16'h8000, "neg_zero");
        step(1'b0, 5'd15, 1'b0, 11'b100_0000_0000, 3'b000, 16'h3C00, "one_exact");
        step(1'b0, 5'd15, 1'b0, 11'b100_0000_0000, 3'b100, 16'h3C00, "tie_even_down");
        step(1'b0, 5'd15, 1'b0, 11'b100_0000_0001, 3'b100, 16'h3C02, "tie_odd_up");
        step(1'b0, 5'd1,  1'b0, 11'b011_1111_1111, 3'b100, 16'h0400, "subnormal_to_normal");
        step(1'b0, 5'd30, 1'b0, 11'b111_1111_1111, 3'b000, 16'h7BFF, "max_finite");
        step(1'b0, 5'd30, 1'b0, 11'b111_1111_1111, 3'b110, 16'h7C00, "round_to_inf");

        rst_n = 1'b0;
        step(1'b1, 5'd20, 1'b1, 11'b001_1010_1010, 3'b101, 16'h0000, "mid_reset");
        rst_n = 1'b1;
        step(1'b1, 5'd28, 1'b0, 11'b001_1110_1010, 3'b111, 16'hEBAC, "resume_after_reset");
        step(1'b0, 5'd10, 1'b0, 11'b000_0000_0001, 3'b101, 16'h0340, "resume_next");

        if (exp_q.size() != 0) begin
            total++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
